// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment driver.
// Glyphs are active-low, with bit0=a through bit6=g.
package seg7_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] glyph_t;

  localparam glyph_t SEG_BLANK = 7'h7F;

  localparam glyph_t G_0 = 7'h40;
  localparam glyph_t G_1 = 7'h79;
  localparam glyph_t G_2 = 7'h24;
  localparam glyph_t G_3 = 7'h30;
  localparam glyph_t G_4 = 7'h19;
  localparam glyph_t G_5 = 7'h12;
  localparam glyph_t G_6 = 7'h02;
  localparam glyph_t G_7 = 7'h78;
  localparam glyph_t G_8 = 7'h00;
  localparam glyph_t G_9 = 7'h18;
  localparam glyph_t G_A = 7'h08;
  localparam glyph_t G_B = 7'h03;
  localparam glyph_t G_C = 7'h46;
  localparam glyph_t G_D = 7'h21;
  localparam glyph_t G_E = 7'h06;
  localparam glyph_t G_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus bundle: nibble load on the host side, scanned segment/anode
// outputs on the display side.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] dat;
  logic                load;
  glyph_t              seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output dat,
    output load,
    input  seg,
    input  an,
    input  frame
  );

  modport slave (
    input  dat,
    input  load,
    output seg,
    output an,
    output frame
  );

endinterface

// File: rtl/seg7_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hex_glyph
  import seg7_pkg::*;
(
  input  nibble_t i_nib,
  output glyph_t  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nib)
      4'h0: o_seg = G_0;
      4'h1: o_seg = G_1;
      4'h2: o_seg = G_2;
      4'h3: o_seg = G_3;
      4'h4: o_seg = G_4;
      4'h5: o_seg = G_5;
      4'h6: o_seg = G_6;
      4'h7: o_seg = G_7;
      4'h8: o_seg = G_8;
      4'h9: o_seg = G_9;
      4'hA: o_seg = G_A;
      4'hB: o_seg = G_B;
      4'hC: o_seg = G_C;
      4'hD: o_seg = G_D;
      4'hE: o_seg = G_E;
      4'hF: o_seg = G_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous data update.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [4*DIGITS-1:0] i_dat,
  input  logic                i_load,
  output logic [6:0]          o_seg,
  output logic [DIGITS-1:0]   o_an,
  output logic                o_frame
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_active;
  glyph_t              r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic                w_cnt_wrap;
  logic                w_frame_end;
  nibble_t             w_digits [DIGITS];
  nibble_t             w_nib;
  glyph_t              w_glyph;
  glyph_t              w_seg_nxt;
  logic [DIGITS-1:0]   w_an_nxt;

  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_wrap && (r_idx == IDX_LAST);

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_digits[k] = r_active[4*k +: 4];
    end
  end

  assign w_nib = w_digits[r_idx];

  seg7_hex_glyph u_glyph (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] w_blank;

  // Blank while every nibble from the top down to k is zero; digit 0 always shows.
  always_comb begin
    logic w_lead;
    w_lead  = 1'b1;
    w_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_lead     = w_lead && (w_digits[k] == 4'h0);
      w_blank[k] = w_lead;
    end
  end

  assign w_seg_nxt = w_blank[r_idx] ? SEG_BLANK : w_glyph;
`else
  assign w_seg_nxt = w_glyph;
`endif

  // First cycle of each slot is a dark guard to avoid ghosting.
  assign w_an_nxt = (r_cnt == '0) ? '1
                  : ~(DIGITS'(1) << r_idx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_seg    <= SEG_BLANK;
      r_an     <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (i_load) begin
        r_shadow <= i_dat;
      end
      if (w_frame_end) begin
        r_active <= i_load ? i_dat : r_shadow;
      end
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_frame <= w_frame_end;
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4).
// Builds with or without SEG7_LZB_EN; expectations follow the macro.
module tb_seg7_scan_driver;

  localparam int D   = 4;
  localparam int DIV = 4;
  localparam int FR  = D * DIV;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(
    .DIGITS      (D),
    .REFRESH_DIV (DIV)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_dat   (bus.dat),
    .i_load  (bus.load),
    .o_seg   (bus.seg),
    .o_an    (bus.an),
    .o_frame (bus.frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [15:0] m_sh;
  logic [15:0] m_act;

  logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] exp_seg(logic [15:0] v, int k);
    logic [3:0] nib;
    nib = 4'((v >> (4 * k)) & 16'hF);
`ifdef SEG7_LZB_EN
    if (k != 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
`endif
    return GL[nib];
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n     = 0;
    m_sh  = '0;
    m_act = '0;
  endtask

  // One clock: drive inputs, predict from the scan position, then compare.
  task automatic cyc(logic ld, logic [15:0] d);
    int         s;
    int         dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fr;
    bus.load = ld;
    bus.dat  = d;
    @(posedge clk);
    s     = n % FR;
    dig   = s / DIV;
    e_an  = (s % DIV == 0) ? 4'hF : ~(4'b0001 << dig);
    e_seg = exp_seg(m_act, dig);
    e_fr  = (s == FR - 1);
    if (s == FR - 1) m_act = ld ? d : m_sh;
    if (ld) m_sh = d;
    n++;
    #1;
    chk("an", 16'(bus.an), 16'(e_an));
    chk("seg", 16'(bus.seg), 16'(e_seg));
    chk("frame", 16'(bus.frame), 16'(e_fr));
    bus.load = 1'b0;
  endtask

  // Advance until the sampled outputs reflect scan position pos.
  task automatic run_to(int pos);
    do cyc(1'b0, 16'h0); while (((n - 1) % FR) != pos);
  endtask

  task automatic slot(string tag, logic [3:0] an, logic [6:0] seg);
    chk({tag, "_an"}, 16'(bus.an), 16'(an));
    chk({tag, "_seg"}, 16'(bus.seg), 16'(seg));
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", 16'(bus.seg), 16'h7F);
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_frame", 16'(bus.frame), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_seg", 16'(bus.seg), 16'h7F);
    chk("rst_hold_an", 16'(bus.an), 16'hF);
    #3 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int fc;
    bus.load = 1'b0;
    bus.dat  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("por_seg", 16'(bus.seg), 16'h7F);
    chk("por_an", 16'(bus.an), 16'hF);
    chk("por_frame", 16'(bus.frame), 16'h0);
    #3 rst = 1'b0;

    cyc(1'b0, 16'h0);
    slot("first_guard", 4'hF, 7'h40);
    cyc(1'b0, 16'h0);
    slot("first_lit", 4'b1110, 7'h40);

    cyc(1'b1, 16'h1234);
    run_to(15);
    run_to(2);  slot("s1234_d0", 4'b1110, 7'h19);
    run_to(6);  slot("s1234_d1", 4'b1101, 7'h30);
    run_to(10); slot("s1234_d2", 4'b1011, 7'h24);
    run_to(14); slot("s1234_d3", 4'b0111, 7'h79);

    run_to(4);
    cyc(1'b1, 16'hABCD);
    run_to(6);  slot("old_d1", 4'b1101, 7'h30);
    run_to(2);  slot("abcd_d0", 4'b1110, 7'h21);
    run_to(14); slot("abcd_d3", 4'b0111, 7'h08);

    fc = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      cyc(1'b0, 16'h0);
      if (bus.frame) fc++;
    end
    chk("frame_count", 16'(fc), 16'd2);

    run_to(14);
    cyc(1'b1, 16'h5678);
    run_to(2);  slot("byp_d0", 4'b1110, 7'h00);
    run_to(6);  slot("byp_d1", 4'b1101, 7'h78);
    run_to(10); slot("byp_d2", 4'b1011, 7'h02);
    run_to(14); slot("byp_d3", 4'b0111, 7'h12);

    run_to(4);
    cyc(1'b1, 16'h9999);
    rst_pulse();
    run_to(15);
    run_to(2);  slot("post_rst_d0", 4'b1110, 7'h40);
    run_to(14); slot("post_rst_d3", 4'b0111, LZ);

    cyc(1'b1, 16'h0050);
    run_to(15);
    run_to(2);  slot("z50_d0", 4'b1110, 7'h40);
    run_to(6);  slot("z50_d1", 4'b1101, 7'h12);
    run_to(10); slot("z50_d2", 4'b1011, LZ);
    run_to(14); slot("z50_d3", 4'b0111, LZ);

    cyc(1'b1, 16'h0000);
    run_to(15);
    run_to(2);  slot("z0_d0", 4'b1110, 7'h40);
    run_to(6);  slot("z0_d1", 4'b1101, LZ);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 5) == 0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, meaning clock cycles per digit slot (>=2).
REQ-003 SHALL have port i_clk  input  1  meaning the single clock, with all state on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port i_dat  input  4*DIGITS  meaning hex nibbles, with digit k at bits [4k+3:4k] and digit 0 rightmost.
REQ-006 SHALL have port i_load  input  1  meaning capture i_dat into the shadow register this cycle.
REQ-007 SHALL have port o_seg  output  7  meaning active-low segments, with bit0=a through bit6=g.
REQ-008 SHALL have port o_an  output  DIGITS  meaning active-low digit enables, one-hot-low or all-high.
REQ-009 SHALL have port o_frame  output  1  meaning a one-cycle pulse marking a completed scan frame.

Function
REQ-010 SHALL keep a prescaler cnt that counts 0..REFRESH_DIV-1 and wraps; it SHALL advance digit index idx (0..DIGITS-1, wrap to 0) when cnt wraps.
REQ-011 SHALL define frame end as the cycle where cnt=REFRESH_DIV-1 and idx=DIGITS-1; a frame lasts DIGITS*REFRESH_DIV cycles.
REQ-012 SHALL capture i_dat into the shadow register on every edge where i_load=1; the last load before frame end wins.
REQ-013 SHALL copy shadow into the active register at frame end only (no tearing mid-frame).
REQ-014 SHALL, when i_load=1 coincides with frame end, load i_dat directly into both shadow and active (bypass).
REQ-015 SHALL register o_seg/o_an/o_frame, each reflecting the cnt/idx/active state of the previous cycle (latency 1).
REQ-016 SHALL drive o_an all-high (guard, anti-ghosting) when cnt=0, and otherwise drive bit idx low and all others high.
REQ-017 SHALL drive o_seg with the glyph of active nibble idx, using standard active-low hex: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x18, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-018 SHALL pulse o_frame high for exactly the one cycle following frame end.
REQ-019 SHALL keep i_load fully independent of the scan; it SHALL never stall or reset cnt or idx.

Reset
REQ-020 SHALL, while i_rst=1, immediately force o_seg=0x7F, o_an all-high, o_frame=0, cnt=0, idx=0, and shadow=active=0.
REQ-021 SHALL, after a mid-frame reset, restart scanning at digit 0, cnt 0, and SHALL discard any pending shadow data.
REQ-022 SHALL start counting at the first rising edge after i_rst deasserts; the first o_an low appears at cycle 2 (cnt=1 registered).

Configuration
REQ-023 SHALL, with macro SEG7_LZB_EN defined, blank leading zeros: scanning from digit DIGITS-1 downward, each zero nibble before the first nonzero one outputs o_seg=0x7F with its o_an still asserted; digit 0 SHALL never be blanked.
REQ-024 SHALL, without SEG7_LZB_EN, display all digits unconditionally, and no blanking logic SHALL be present.

Structure
REQ-025 SHALL place the glyph constants, SEG_BLANK=7'h7F and a 4-bit nibble type in shared package seg7_pkg.
REQ-026 SHALL implement nibble-to-glyph decoding in combinational sub-module seg7_hex_glyph (4-bit in, 7-bit out); the scan logic, shadow/active registers and LZB SHALL stay in seg7_scan_driver.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-027 SHALL cover: reset asserted mid-slot -> o_seg=0x7F and o_an=4'hF in the same cycle, o_frame=0; after release o_an=4'b1110 first at cycle 2.
REQ-028 SHALL cover: load 0x1234, wait for frame end -> slots show (o_an,o_seg) = (1110,0x19), (1101,0x30), (1011,0x24), (0111,0x79), each 3 cycles long, preceded by a 1-cycle 4'hF guard.
REQ-029 SHALL cover: load 0xABCD at idx=1 -> the current frame still shows the old data; from the next frame digit 0 shows 0x21, digit 3 shows 0x08, and o_frame pulses once every 16 cycles.
REQ-030 SHALL cover: i_load=1 with 0x5678 exactly on a frame-end cycle -> the very next frame shows 8,7,6,5 (0x00, 0x78, 0x02, 0x12).
REQ-031 SHALL cover: with SEG7_LZB_EN, load 0x0050 -> digits 3,2 give o_seg=0x7F, digit 1 gives 0x12, digit 0 gives 0x40; load 0x0000 -> only digit 0 gives 0x40.
REQ-032 SHALL cover: without SEG7_LZB_EN, load 0x0050 -> digits 3,2 give 0x40.
